led_glow_pwm_multi: RTL and testbench

Parametrised multi-channel LED glow generator, successor to the single-channel 4-bit PWM glow/police-light top.
- One shared triangle (breathing) waveform with a prescaled step rate.
- Per-channel 2-bit mode selects off, solid, glow or inverted-glow, so alternating red/blue glow is a mode setting.
- Global brightness cap via a scaling multiply.
- Sits between top-level LED pins and control logic (buttons, counters).

---
 rtl/led_glow_pkg.sv | 24 ++
 rtl/led_glow_pwm_multi_if.sv | 14 +
 rtl/glow_triangle_gen.sv | 69 ++++++
 rtl/led_glow_pwm_multi.sv | 74 +++++++
 tb/tb_led_glow_pwm_multi.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/led_glow_pkg.sv
// Shared types and helpers for the multi-channel LED glow generator.
package led_glow_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_SOLID    = 2'b01,
        MODE_GLOW     = 2'b10,
        MODE_GLOW_INV = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int PRESC_W = 24;

    // (x*level + level) >> w; 32-bit operands cover PWM_W up to 16 without overflow.
    function automatic logic [31:0] scale(input logic [31:0] x, input logic [31:0] level,
                                          input int w);
        return (x * level + level) >> w;
    endfunction

endpackage

// File: rtl/led_glow_pwm_multi_if.sv
// Control/status bundle between the glow generator and its controller.
interface led_glow_pwm_multi_if #(
    parameter int N_CH  = 8,
    parameter int PWM_W = 8
);
    logic              enable;
    logic [2*N_CH-1:0] mode;
    logic [PWM_W-1:0]  max_level;
    logic [N_CH-1:0]   led;
    logic              cycle_tick;

    modport master (output enable, mode, max_level, input led, cycle_tick);
    modport slave  (input enable, mode, max_level, output led, cycle_tick);
endinterface

// File: rtl/glow_triangle_gen.sv
// Prescaled triangle (breathing) level 0..MAX..0 with an end-of-period tick.
module glow_triangle_gen
    import led_glow_pkg::*;
#(
    parameter int PWM_W    = 8,
    parameter int STEP_DIV = 49020
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [PWM_W-1:0] level,
    output logic             cycle_tick
);
    localparam logic [PWM_W-1:0]   MAX        = {PWM_W{1'b1}};
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [PWM_W-1:0]   tri_lvl, tri_nxt;
    dir_e               dir, dir_nxt;
    logic               tick_nxt;
    logic               step;

    assign step  = (presc == PRESC_LAST);
    assign level = tri_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            tri_lvl    <= '0;
            dir        <= DIR_UP;
            cycle_tick <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            tri_lvl    <= tri_nxt;
            dir        <= dir_nxt;
            cycle_tick <= tick_nxt;
        end
    end

    // Everything holds while disabled, so the waveform resumes where it stopped.
    always_comb begin
        presc_nxt = presc;
        tri_nxt   = tri_lvl;
        dir_nxt   = dir;
        tick_nxt  = 1'b0;
        if (enable) begin
            presc_nxt = step ? '0 : presc + 1'b1;
            if (step) begin
                if (dir == DIR_UP) begin
                    if (tri_lvl == MAX - 1'b1) begin
                        tri_nxt = MAX;
                        dir_nxt = DIR_DOWN;
                    end else begin
                        tri_nxt = tri_lvl + 1'b1;
                    end
                end else begin
                    if (tri_lvl == PWM_W'(1)) begin
                        tri_nxt  = '0;
                        dir_nxt  = DIR_UP;
                        tick_nxt = 1'b1;
                    end else begin
                        tri_nxt = tri_lvl - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/led_glow_pwm_multi.sv
// Multi-channel PWM LED driver: shared frame counter, per-channel mode-selected duty.
module led_glow_pwm_multi
    import led_glow_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int PWM_W    = 8,
    parameter int STEP_DIV = 49020
) (
    input  logic                  clk_25mhz,
    input  logic                  rst_n,
    led_glow_pwm_multi_if.slave   bus
);
    localparam logic [PWM_W-1:0] MAX = {PWM_W{1'b1}};

    logic [PWM_W-1:0] pwm_cnt_p0;
    logic [PWM_W-1:0] tri_lvl;
    logic             frame_end;

    assign frame_end = (pwm_cnt_p0 == MAX - 1'b1);

    glow_triangle_gen #(
        .PWM_W    (PWM_W),
        .STEP_DIV (STEP_DIV)
    ) u_tri (
        .clk        (clk_25mhz),
        .rst_n      (rst_n),
        .enable     (bus.enable),
        .level      (tri_lvl),
        .cycle_tick (bus.cycle_tick)
    );

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_p0 <= '0;
        end else if (bus.enable) begin
            pwm_cnt_p0 <= frame_end ? '0 : pwm_cnt_p0 + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PWM_W-1:0] duty_sel;
        logic [PWM_W-1:0] duty_p0;
        logic             led_p1;

        always_comb begin
            duty_sel = '0;
            case (mode_e'(bus.mode[2*i +: 2]))
                MODE_SOLID:    duty_sel = bus.max_level;
                MODE_GLOW:     duty_sel = PWM_W'(scale(32'(tri_lvl), 32'(bus.max_level), PWM_W));
                MODE_GLOW_INV: duty_sel = PWM_W'(scale(32'(MAX - tri_lvl), 32'(bus.max_level),
                                                       PWM_W));
                default:       duty_sel = '0;
            endcase
        end

        // ---- stage p0 -> p1: duty reloads only on the frame boundary; compare is registered
        always_ff @(posedge clk_25mhz or negedge rst_n) begin
            if (!rst_n) begin
                duty_p0 <= '0;
                led_p1  <= 1'b0;
            end else begin
                if (!bus.enable) begin
                    duty_p0 <= '0;
                end else if (frame_end) begin
                    duty_p0 <= duty_sel;
                end
                led_p1 <= bus.enable & (pwm_cnt_p0 < duty_p0);
            end
        end

        assign bus.led[i] = led_p1;
    end

endmodule

// File: tb/tb_led_glow_pwm_multi.sv
// Scoreboard bench: per-frame LED high counts and cycle_tick edge positions.
module tb_led_glow_pwm_multi;
    import led_glow_pkg::*;

    localparam int N_CH     = 4;
    localparam int PWM_W    = 4;
    localparam int STEP_DIV = 2;
    localparam int FRAME    = 15;

    logic clk_25mhz = 1'b0;
    logic rst_n     = 1'b0;

    always #5 clk_25mhz = ~clk_25mhz;

    led_glow_pwm_multi_if #(.N_CH(N_CH), .PWM_W(PWM_W)) bus ();

    led_glow_pwm_multi #(
        .N_CH     (N_CH),
        .PWM_W    (PWM_W),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] frame_q[$];
    int          tick_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    endfunction

    task automatic push_all(input int c);
        frame_q.push_back(pk(c, c, c, c));
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_25mhz);
    endtask

    task automatic start(input logic [7:0] m, input logic [3:0] ml);
        rst_n         = 1'b0;
        bus.enable    = 1'b1;
        bus.mode      = m;
        bus.max_level = ml;
        wait_neg(2);
        rst_n = 1'b1;
    endtask

    // Monitor: windows of FRAME enabled clocks align with the DUT frame counter.
    initial begin : monitor
        int          ecount;
        int          phase;
        int          acc[N_CH];
        logic        en_s;
        logic [15:0] got;
        ecount = 0;
        phase  = 0;
        foreach (acc[c]) acc[c] = 0;
        forever begin
            @(posedge clk_25mhz);
            en_s = bus.enable;
            #1;
            if (!rst_n) begin
                ecount = 0;
                phase  = 0;
                foreach (acc[c]) acc[c] = 0;
            end else begin
                ecount++;
                if (bus.cycle_tick) begin
                    if (tick_q.size() == 0) check("tick_extra", 32'(ecount), 32'(0));
                    else check("tick_edge", 32'(ecount), 32'(tick_q.pop_front()));
                end
                if (en_s) begin
                    for (int c = 0; c < N_CH; c++) acc[c] += int'(bus.led[c]);
                    phase++;
                    if (phase == FRAME) begin
                        got = pk(acc[0], acc[1], acc[2], acc[3]);
                        if (frame_q.size() == 0) check("frame_extra", 32'(frame_q.size()), 32'(1));
                        else check("frame_counts", 32'(got), 32'(frame_q.pop_front()));
                        phase = 0;
                        foreach (acc[c]) acc[c] = 0;
                    end
                end else begin
                    check("led_disabled", 32'(bus.led), 32'(0));
                end
            end
        end
    end

    initial begin : stimulus
        bus.enable    = 1'b0;
        bus.mode      = '0;
        bus.max_level = '0;

        // SOLID on ch0..2, ch3 OFF; max_level changes mid-frame land at the next boundary
        start(8'b00_01_01_01, 4'd0);
        frame_q.push_back(pk(0, 0, 0, 0));
        frame_q.push_back(pk(0, 0, 0, 0));
        frame_q.push_back(pk(7, 7, 7, 0));
        frame_q.push_back(pk(15, 15, 15, 0));
        tick_q.push_back(60);
        wait_neg(20);
        bus.max_level = 4'd7;
        wait_neg(15);
        bus.max_level = 4'd15;
        wait_neg(25);
        check("solid_led_pre_rst", 32'(bus.led), 32'(4'b0111));
        check("tick_pre_rst", 32'(bus.cycle_tick), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(bus.led), 32'(0));
        check("async_rst_tick", 32'(bus.cycle_tick), 32'(0));

        // All GLOW at full scale: high count equals tri latched at frame start
        start(8'b10_10_10_10, 4'd15);
        push_all(0); push_all(7); push_all(14); push_all(8);
        push_all(1); push_all(7); push_all(14); push_all(8);
        tick_q.push_back(60);
        tick_q.push_back(120);
        wait_neg(120);

        // Police alternation: ch0/1 GLOW, ch2/3 GLOW_INV
        start(8'b11_11_10_10, 4'd15);
        frame_q.push_back(pk(0, 0, 0, 0));
        frame_q.push_back(pk(7, 7, 8, 8));
        frame_q.push_back(pk(14, 14, 1, 1));
        frame_q.push_back(pk(8, 8, 7, 7));
        frame_q.push_back(pk(1, 1, 14, 14));
        tick_q.push_back(60);
        wait_neg(75);

        // Scaling with max_level=8: GLOW, GLOW_INV, SOLID, OFF
        start(8'b00_01_11_10, 4'd8);
        frame_q.push_back(pk(0, 0, 0, 0));
        frame_q.push_back(pk(4, 4, 8, 0));
        frame_q.push_back(pk(7, 1, 8, 0));
        frame_q.push_back(pk(4, 4, 8, 0));
        frame_q.push_back(pk(1, 7, 8, 0));
        tick_q.push_back(60);
        wait_neg(75);

        // Freeze at tri=9 (rising) for 100 clocks; waveform resumes, tick shifts by 100
        start(8'b10_10_10_10, 4'd15);
        push_all(0); push_all(3); push_all(14); push_all(8); push_all(1);
        tick_q.push_back(160);
        wait_neg(18);
        bus.enable = 1'b0;
        wait_neg(100);
        bus.enable = 1'b1;
        wait_neg(57);

        check("frames_left", 32'(frame_q.size()), 32'(0));
        check("ticks_left", 32'(tick_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
